// File: rtl/uart_arb_pkg.sv
// rtl/uart_arb_pkg.sv - shared types, parameter defaults and width helper for the UART TX arbiter
package uart_arb_pkg;

  typedef enum logic {IDLE = 1'b0, GRANT = 1'b1} arb_state_t;

  localparam int N_REQ_DEF   = 4;
  localparam int TIMEOUT_DEF = 1024;

  function automatic int id_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// rtl/rr_pick.sv - combinational round-robin pick: first set request at or after ptr, wrapping
module rr_pick
  import uart_arb_pkg::*;
#(
  parameter int N_REQ = N_REQ_DEF,
  parameter int W     = id_w(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [W-1:0]     ptr,
  output logic [W-1:0]     idx,
  output logic             any
);

  logic [W-1:0] cand;

  always_comb begin
    idx  = '0;
    any  = 1'b0;
    cand = '0;
    for (int i = 0; i < N_REQ; i++) begin
      cand = W'((int'(ptr) + i) % N_REQ);
      if (!any && req[cand]) begin
        any = 1'b1;
        idx = cand;
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// rtl/uart_tx_arbiter.sv - packet-level round-robin arbiter onto one uart TX FIFO write port
// Optional grant revocation on grantee stall is enabled by defining UART_ARB_TIMEOUT_EN.
module uart_tx_arbiter
  import uart_arb_pkg::*;
#(
  parameter int N_REQ   = N_REQ_DEF,
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [N_REQ-1:0]          req_valid,
  input  logic [8*N_REQ-1:0]        req_data,
  input  logic [N_REQ-1:0]          req_last,
  output logic [N_REQ-1:0]          req_ready,
  output logic                      wr_uart,
  output logic [7:0]                w_data,
  input  logic                      tx_full,
  output logic                      busy,
  output logic [id_w(N_REQ)-1:0]    grant_id,
  output logic                      timeout_err
);

  localparam int W = id_w(N_REQ);

  arb_state_t   state, state_nxt;
  logic [W-1:0] ptr, next_ptr, pick_idx;
  logic         pick_any, xfer, done, expire;
  logic [7:0]   lane [N_REQ];

  rr_pick #(.N_REQ(N_REQ), .W(W)) u_pick (
    .req (req_valid),
    .ptr (ptr),
    .idx (pick_idx),
    .any (pick_any)
  );

  always_comb begin
    for (int i = 0; i < N_REQ; i++) lane[i] = req_data[8*i +: 8];
  end

  assign xfer     = (state == GRANT) && req_valid[grant_id] && !tx_full;
  assign done     = xfer && req_last[grant_id];
  assign next_ptr = (grant_id == W'(N_REQ - 1)) ? '0 : grant_id + 1'b1;

`ifdef UART_ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT + 1);
  logic [CW-1:0] stall_cnt;

  // Only an absent grantee counts as a stall; tx_full backpressure just holds the count.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall_cnt   <= '0;
      timeout_err <= 1'b0;
    end else begin
      timeout_err <= expire;
      if (state != GRANT || xfer) stall_cnt <= '0;
      else if (!req_valid[grant_id]) stall_cnt <= stall_cnt + 1'b1;
    end
  end

  assign expire = (state == GRANT) && !req_valid[grant_id] && (stall_cnt == CW'(TIMEOUT - 1));
`else
  logic unused_timeout;
  assign unused_timeout = ^TIMEOUT;
  assign expire         = 1'b0;
  assign timeout_err    = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      grant_id <= '0;
      ptr      <= '0;
    end else begin
      state <= state_nxt;
      if (state == IDLE && pick_any) grant_id <= pick_idx;
      if (state == GRANT && state_nxt == IDLE) ptr <= next_ptr;
    end
  end

  always_comb begin
    state_nxt = state;
    if (state == IDLE) begin
      if (pick_any) state_nxt = GRANT;
    end else if (done || expire) begin
      state_nxt = IDLE;
    end
  end

  always_comb begin
    req_ready = '0;
    wr_uart   = 1'b0;
    w_data    = 8'h00;
    busy      = (state == GRANT);
    if (state == GRANT) begin
      wr_uart             = req_valid[grant_id] & ~tx_full;
      req_ready[grant_id] = wr_uart;
      if (wr_uart) w_data = lane[grant_id];
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb/tb_uart_tx_arbiter.sv - directed self-checking bench for uart_tx_arbiter (N_REQ=4, TIMEOUT=16)
module tb_uart_tx_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  req_valid, req_last, req_ready;
  logic [31:0] req_data;
  logic        wr_uart, tx_full, busy, timeout_err;
  logic [7:0]  w_data;
  logic [1:0]  grant_id;

  int checks = 0;
  int fails  = 0;
  int writes = 0;
  int idle   = 0;

  logic [7:0] qd [4][$];
  logic       ql [4][$];
  logic [7:0] exp_d [$];
  logic [1:0] exp_g [$];

  uart_tx_arbiter #(.N_REQ(4), .TIMEOUT(16)) dut (
    .clk         (clk),
    .reset       (reset),
    .req_valid   (req_valid),
    .req_data    (req_data),
    .req_last    (req_last),
    .req_ready   (req_ready),
    .wr_uart     (wr_uart),
    .w_data      (w_data),
    .tx_full     (tx_full),
    .busy        (busy),
    .grant_id    (grant_id),
    .timeout_err (timeout_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push(input int r, input logic [7:0] d, input logic l);
    qd[r].push_back(d);
    ql[r].push_back(l);
  endtask

  task automatic expect_w(input logic [1:0] g, input logic [7:0] d);
    exp_g.push_back(g);
    exp_d.push_back(d);
  endtask

  task automatic drive();
    for (int r = 0; r < 4; r++) begin
      if (qd[r].size() > 0) begin
        req_valid[r]        = 1'b1;
        req_data[8*r +: 8]  = qd[r][0];
        req_last[r]         = ql[r][0];
      end else begin
        req_valid[r]        = 1'b0;
        req_data[8*r +: 8]  = 8'h00;
        req_last[r]         = 1'b0;
      end
    end
  endtask

  // Check any write presented this cycle, clock once, then retire accepted bytes.
  task automatic cycle();
    logic [3:0] rdy;
    rdy = req_ready;
    if (wr_uart === 1'b1) begin
      writes++;
      chk("write_expected", 32'(exp_d.size() > 0), 32'd1);
      if (exp_d.size() > 0) begin
        chk("w_data", w_data, exp_d.pop_front());
        chk("write_grant", grant_id, exp_g.pop_front());
      end
    end
    @(posedge clk);
    #1;
    for (int r = 0; r < 4; r++) begin
      if (rdy[r] && qd[r].size() > 0) begin
        void'(qd[r].pop_front());
        void'(ql[r].pop_front());
      end
    end
    drive();
    #1;
  endtask

  initial begin
    reset   = 1'b0;
    tx_full = 1'b0;
    drive();
    #3;
    chk("rst_busy", busy, 0);
    chk("rst_wr", wr_uart, 0);
    chk("rst_wdata", w_data, 0);
    chk("rst_grant", grant_id, 0);
    chk("rst_ready", req_ready, 0);
    chk("rst_timeout", timeout_err, 0);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;

    // single packet from requester 2
    push(2, 8'h48, 0); push(2, 8'h4F, 0); push(2, 8'h4C, 0); push(2, 8'h41, 1);
    expect_w(2, 8'h48); expect_w(2, 8'h4F); expect_w(2, 8'h4C); expect_w(2, 8'h41);
    drive();
    #1;
    chk("idle_busy", busy, 0);
    chk("idle_no_write", wr_uart, 0);
    cycle();
    chk("single_grant", grant_id, 2);
    chk("single_busy", busy, 1);
    writes = 0;
    for (int i = 0; i < 4; i++) cycle();
    chk("single_writes", writes, 4);
    chk("single_busy_fall", busy, 0);
    chk("single_last_id", grant_id, 2);

    // round robin over 0,1,3 from a fresh pointer
    reset = 1'b0;
    #1;
    reset = 1'b1;
    push(0, 8'hA0, 0); push(0, 8'hA1, 1); push(0, 8'hA2, 0); push(0, 8'hA3, 1);
    push(1, 8'hB0, 0); push(1, 8'hB1, 1);
    push(3, 8'hD0, 0); push(3, 8'hD1, 1);
    expect_w(0, 8'hA0); expect_w(0, 8'hA1); expect_w(1, 8'hB0); expect_w(1, 8'hB1);
    expect_w(3, 8'hD0); expect_w(3, 8'hD1); expect_w(0, 8'hA2); expect_w(0, 8'hA3);
    drive();
    #1;
    writes = 0;
    idle   = 0;
    for (int i = 0; i < 12; i++) begin
      if (busy === 1'b0) idle++;
      cycle();
    end
    chk("rr_writes", writes, 8);
    chk("rr_idle_cycles", idle, 4);

    // backpressure on requester 1
    push(1, 8'h31, 0); push(1, 8'h32, 0); push(1, 8'h33, 1);
    expect_w(1, 8'h31); expect_w(1, 8'h32); expect_w(1, 8'h33);
    drive();
    #1;
    cycle();
    cycle();
    tx_full = 1'b1;
    #1;
    for (int i = 0; i < 10; i++) begin
      chk("full_no_write", wr_uart, 0);
      chk("full_no_ready", req_ready, 0);
      chk("full_grant_kept", {busy, grant_id}, {1'b1, 2'd1});
      cycle();
    end
    tx_full = 1'b0;
    #1;
    chk("write_after_full", wr_uart, 1);
    cycle();
    cycle();

    // requester 1 arrives on requester 0's last byte
    push(0, 8'h40, 0); push(0, 8'h41, 1);
    expect_w(0, 8'h40); expect_w(0, 8'h41); expect_w(1, 8'h50);
    drive();
    #1;
    cycle();
    cycle();
    push(1, 8'h50, 1);
    drive();
    #1;
    chk("only_grantee_ready", req_ready, 4'b0001);
    cycle();
    chk("boundary_idle", {busy, wr_uart}, 2'b00);
    cycle();
    chk("boundary_grant", grant_id, 1);
    cycle();

    // reset mid-packet
    push(3, 8'h60, 0); push(3, 8'h61, 0); push(3, 8'h62, 0); push(3, 8'h63, 0); push(3, 8'h64, 1);
    expect_w(3, 8'h60); expect_w(3, 8'h61);
    drive();
    #1;
    cycle();
    cycle();
    cycle();
    reset = 1'b0;
    #1;
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_wr", wr_uart, 0);
    chk("mid_rst_ready", req_ready, 0);
    chk("mid_rst_wdata", w_data, 0);
    chk("mid_rst_grant", grant_id, 0);
    qd[3].delete();
    ql[3].delete();
    push(0, 8'h70, 1); push(3, 8'h80, 1);
    expect_w(0, 8'h70); expect_w(3, 8'h80);
    drive();
    #1;
    reset = 1'b1;
    cycle();
    chk("post_rst_grant", grant_id, 0);
    cycle();
    cycle();
    chk("post_rst_next", grant_id, 3);
    cycle();

    // grantee stalls with requester 2 waiting
    push(1, 8'h90, 0); push(2, 8'hA5, 1);
    expect_w(1, 8'h90);
    drive();
    #1;
    cycle();
    cycle();
`ifdef UART_ARB_TIMEOUT_EN
    for (int i = 0; i < 16; i++) begin
      chk("stall_held", {busy, grant_id}, {1'b1, 2'd1});
      chk("stall_no_err", timeout_err, 0);
      cycle();
    end
    chk("timeout_pulse", timeout_err, 1);
    chk("timeout_idle", busy, 0);
    expect_w(2, 8'hA5);
    cycle();
    chk("timeout_next_grant", grant_id, 2);
    chk("timeout_one_pulse", timeout_err, 0);
    cycle();
`else
    for (int i = 0; i < 20; i++) begin
      chk("stall_held", {busy, grant_id}, {1'b1, 2'd1});
      chk("stall_no_err", timeout_err, 0);
      cycle();
    end
    push(1, 8'h91, 1);
    expect_w(1, 8'h91); expect_w(2, 8'hA5);
    drive();
    #1;
    cycle();
    cycle();
    chk("stall_next_grant", grant_id, 2);
    cycle();
`endif
    chk("all_writes_seen", exp_d.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/uart_tx_arbiter.md
# uart_tx_arbiter

Packet-level round-robin arbiter that shares a single `uart` transmit path (its `wr_uart` / `w_data` / `tx_full` write port) between several on-chip requesters. Each requester streams a packet of bytes, marking the final byte with `last`. The block sits between the requesters and the `uart` instance. A granted requester owns the TX FIFO until its last byte is written, so packets never interleave on the serial line.

## Interface
- `N_REQ`, 4: number of requesters (2..8).
- `TIMEOUT`, 1024: stall cycles before a grant is revoked (used only with the timeout feature).
- `clk` in 1: system clock (50 MHz nominal).
- `reset` in 1: one clock domain; reset is asynchronous and active-low (0 = reset).
- `req_valid` in N_REQ: requester i presents a byte.
- `req_data` in 8*N_REQ: byte of requester i, in bits [8i+7:8i].
- `req_last` in N_REQ: the byte is the final byte of its packet.
- `req_ready` out N_REQ: byte of requester i is accepted this cycle.
- `wr_uart` out 1: write strobe to the `uart` TX FIFO.
- `w_data` out 8: byte to the `uart` TX FIFO.
- `tx_full` in 1: the `uart` TX FIFO is full.
- `busy` out 1: a grant is active.
- `grant_id` out $clog2(N_REQ): index of the current or last grantee.
- `timeout_err` out 1: one-cycle pulse when a grant is revoked by timeout.

## Operation
- FSM states are IDLE and GRANT. Reset puts the FSM in IDLE, sets the priority pointer to 0, and sets `grant_id` to 0. All outputs are 0 during reset.
- IDLE:
  - If any `req_valid` bit is high, select the first valid index at or after the pointer, wrapping modulo N_REQ.
  - Register that index in `grant_id` and go to GRANT.
  - No byte is transferred while in IDLE.
- GRANT, with g = `grant_id`:
  - `req_ready[g] = req_valid[g] & ~tx_full`. All other `req_ready` bits are 0.
  - `wr_uart = req_ready[g]`.
  - `w_data = req_data[g]` when `wr_uart` is 1, otherwise 0.
  - A byte transfers when both `req_valid[g]` and `req_ready[g]` are 1.
  - When a byte transfers with `req_last[g]` = 1, go to IDLE and set the pointer to (g+1) mod N_REQ.
- Other requesters' `req_valid` inputs are ignored while a grant is active. Requesters must hold `valid` and `data` stable until `ready`.
- `tx_full` high stalls the transfer. The grant is held and no write is issued.
- A request from a non-granted requester that arrives on the same cycle as the last-byte transfer is considered in the following IDLE cycle.
- Reset asserted mid-packet drops the grant immediately. The packet's remaining bytes are abandoned. Bytes already written stay in the `uart` FIFO.

## Timing
- Arbitration latency is 1 cycle. With `req_valid` high at edge k in IDLE, `busy` and `grant_id` update at k+1. The first `wr_uart` can occur in the cycle after edge k+1.
- In GRANT, writes are combinational: one byte per cycle while `valid` is high and `tx_full` is low. Back-to-back writes are legal because the `uart` FIFO's `tx_full` reflects a write by the next edge.
- Each packet costs exactly one IDLE cycle of overhead.
- `busy` is registered: 1 exactly while in GRANT.

## Configuration
- `UART_ARB_TIMEOUT_EN` defined:
  - A stall counter runs while in GRANT. It increments on every cycle where `req_valid[g]` = 0 and clears on every transfer. Stalls caused by `tx_full` do not count.
  - When the counter reaches TIMEOUT: `timeout_err` pulses for 1 cycle, the FSM goes to IDLE, and the pointer advances to g+1.
- Undefined: no counter is built. A grant is held indefinitely, and `timeout_err` is tied to 0.

## Structure
- Package `uart_arb_pkg` holds:
  - the state enum `arb_state_t` {IDLE, GRANT};
  - localparam defaults for N_REQ and TIMEOUT;
  - the width helper for `grant_id`.
- Sub-module `rr_pick`: combinational round-robin selection. Inputs are the request vector and the pointer. Outputs are the winning index and an `any` flag. It is instantiated once.

## Test plan
- **Single packet:** requester 2 sends 0x48, 0x4F, 0x4C, 0x41 with `last` on 0x41.
  - `grant_id` = 2 one cycle after `valid`.
  - Four consecutive `wr_uart` pulses carry those bytes in order.
  - `busy` falls the cycle after 0x41.
- **Round-robin:** requesters 0, 1 and 3 each hold 2-byte packets pending from reset. Grants go 0, 1, 3, and the next pending request from 0 is served after 3. Bytes never interleave.
- **Backpressure:** `tx_full` is held high for 10 cycles mid-packet. There is no `wr_uart` and `req_ready` stays 0. The grant is kept, and the next byte is written on the first cycle `tx_full` is low.
- **Contention at boundary:** requester 1 raises `valid` on the same cycle requester 0's last byte transfers. There is one IDLE cycle, then `grant_id` = 1.
- **Reset mid-packet:** `reset` is driven to 0 after 2 of 5 bytes. All outputs go to 0 asynchronously. After release, the pointer is 0 and requester 0 wins.
- **Timeout (`UART_ARB_TIMEOUT_EN`, TIMEOUT = 16):** the grantee drops `valid` for 16 cycles. `timeout_err` pulses once and the grant moves to the next pending requester. Without the macro, the grant is held and `timeout_err` stays 0.
